// File: rtl/norm_l_arbiter_pkg.sv
// norm_l_arbiter_pkg
// Shared definitions for the norm_l arbiter slice:
//   - FSM state encodings (IDLE=0, LAUNCH=1, WAIT=2, RESP=3)
//   - default requester count and watchdog timeout
//   - rr_next_idx: round-robin successor of an index, wrapping at n-1
package norm_l_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int DEFAULT_N_REQ   = 4;
    // The core needs at most 33 cycles; 48 leaves margin before declaring it hung.
    localparam int DEFAULT_TIMEOUT = 48;

    // Successor of idx in a ring of n entries (n need not be a power of two).
    function automatic int rr_next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/norm_l_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector.
//   req        in   N_REQ   request vector
//   ptr        in   PTR_W   highest-priority index for this pick
//   winner_oh  out  N_REQ   one-hot winner (zero when no request)
//   winner_idx out  PTR_W   binary winner index (zero when no request)
//   any        out  1       at least one request present
// The winner is the first set request at or above ptr, wrapping from
// N_REQ-1 back to 0. The scan never produces an index >= N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner_oh,
    output logic [PTR_W-1:0] winner_idx,
    output logic             any
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    logic [PTR_W:0]   slot;
    logic [PTR_W-1:0] cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        slot       = '0;
        cand       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (slot >= (PTR_W + 1)'(N_REQ)) begin
                slot = slot - (PTR_W + 1)'(N_REQ);
            end
            cand = slot[PTR_W-1:0];
            if (!any && req[cand]) begin
                any             = 1'b1;
                winner_idx      = cand;
                winner_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/norm_l_arbiter.sv
// norm_l_arbiter
// Shares one norm_l normalisation core among N_REQ requesters. A round-robin
// pick in IDLE latches the winner's operand, the core is started with a
// one-cycle core_ready, the result is captured on core_done and returned to
// the winner with a one-cycle done pulse. A watchdog aborts a hung core.
//
// Ports
//   clk         in   1          clock, posedge
//   reset       in   1          asynchronous, active-low
//   req         in   N_REQ      level requests, sampled only in IDLE
//   var1_bus    in   32*N_REQ   operand of requester i at [32*i+31:32*i]
//   grant       out  N_REQ      one-hot pulse in the cycle the operand is latched
//   done        out  N_REQ      one-hot pulse when norm_out is valid
//   norm_out    out  16         result, held until the next done
//   err         out  1          sticky core-timeout flag, cleared by reset only
//   busy        out  1          high in every state but IDLE
//   core_var1   out  32         registered operand to the core
//   core_ready  out  1          start pulse to the core
//   core_reset  out  1          active-high reset to the core
//   core_norm   in   16         core result
//   core_done   in   1          core done pulse
//   state_dbg   out  2          current FSM state (IDLE/LAUNCH/WAIT/RESP)
//
// Handshake: a requester holds req until it sees its grant pulse and drops
// it on the following cycle; its operand only has to be valid during the
// IDLE cycle that produces the grant. The core is started by core_ready and
// answers with a single core_done pulse; grant, done and core_ready are all
// flop outputs, so no input reaches them combinationally.
module norm_l_arbiter
    import norm_l_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int PTR_W   = 2,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   var1_bus,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [15:0]           norm_out,
    output logic                  err,
    output logic                  busy,
    output logic [31:0]           core_var1,
    output logic                  core_ready,
    output logic                  core_reset,
    input  logic [15:0]           core_norm,
    input  logic                  core_done,
    output logic [1:0]            state_dbg
);

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]  IDX_LAST  = PTR_W'(N_REQ - 1);

    logic [1:0]         state_q,     state_d;
    logic [PTR_W-1:0]   ptr_q,       ptr_d;
    logic [PTR_W-1:0]   winner_q,    winner_d;
    logic [WDOG_W-1:0]  wdog_q,      wdog_d;
    logic [N_REQ-1:0]   grant_q,     grant_d;
    logic [N_REQ-1:0]   done_q,      done_d;
    logic [15:0]        norm_out_q,  norm_out_d;
    logic               err_q,       err_d;
    logic [31:0]        core_var1_q, core_var1_d;
    logic               core_ready_q, core_ready_d;
    logic               abort_q,     abort_d;

    logic [N_REQ-1:0]   pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    logic [31:0]        sel_var1;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // AND-OR operand mux driven by the one-hot pick.
    always_comb begin
        sel_var1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) begin
                sel_var1 = var1_bus[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        winner_d     = winner_q;
        wdog_d       = wdog_q;
        grant_d      = '0;
        done_d       = '0;
        norm_out_d   = norm_out_q;
        err_d        = err_q;
        core_var1_d  = core_var1_q;
        core_ready_d = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    winner_d     = pick_idx;
                    grant_d      = pick_oh;
                    core_var1_d  = sel_var1;
                    // Registered here so the start pulse is high during LAUNCH.
                    core_ready_d = 1'b1;
                    state_d      = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    norm_out_d       = core_norm;
                    done_d[winner_q] = 1'b1;
                    state_d          = ST_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    // Hung core: answer the requester with 0, flag it and
                    // pulse core_reset so the core is back in INIT.
                    err_d            = 1'b1;
                    norm_out_d       = '0;
                    abort_d          = 1'b1;
                    done_d[winner_q] = 1'b1;
                    state_d          = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_RESP: begin
                // Just-served requester becomes lowest priority.
                ptr_d   = (winner_q == IDX_LAST) ? '0 : winner_q + PTR_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            winner_q     <= '0;
            wdog_q       <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            norm_out_q   <= '0;
            err_q        <= 1'b0;
            core_var1_q  <= '0;
            core_ready_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            winner_q     <= winner_d;
            wdog_q       <= wdog_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            norm_out_q   <= norm_out_d;
            err_q        <= err_d;
            core_var1_q  <= core_var1_d;
            core_ready_q <= core_ready_d;
            abort_q      <= abort_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign norm_out   = norm_out_q;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE);
    assign core_var1  = core_var1_q;
    assign core_ready = core_ready_q;
    // Held high throughout our own reset so the core leaves reset with us.
    assign core_reset = ~reset | abort_q;
    assign state_dbg  = state_q;

endmodule
